// File: rtl/wb_cmd_master_pkg.sv
// Shared types and widths for the Wishbone command master.
package wb_cmd_master_pkg;

    localparam int unsigned AdrW = 32;
    localparam int unsigned DatW = 32;
    localparam int unsigned SelW = 4;

    typedef enum logic [1:0] {
        StIdle,
        StBus,
        StResp
    } wbm_state_t;

endpackage

// File: rtl/wb_cmd_master_if.sv
// Command, response and Wishbone master signals bundled for wb_cmd_master.
interface wb_cmd_master_if;
    import wb_cmd_master_pkg::*;

    logic            cmd_valid;
    logic            cmd_ready;
    logic            cmd_we;
    logic [AdrW-1:0] cmd_adr;
    logic [DatW-1:0] cmd_dat;
    logic [SelW-1:0] cmd_sel;

    logic            rsp_valid;
    logic            rsp_ready;
    logic [DatW-1:0] rsp_dat;
    logic            rsp_err;

    logic            wbm_cyc_o;
    logic            wbm_stb_o;
    logic            wbm_we_o;
    logic [AdrW-1:0] wbm_adr_o;
    logic [DatW-1:0] wbm_dat_o;
    logic [SelW-1:0] wbm_sel_o;
    logic            wbm_ack_i;
    logic [DatW-1:0] wbm_dat_i;

    modport master (
        input  cmd_valid, cmd_we, cmd_adr, cmd_dat, cmd_sel,
        input  rsp_ready,
        input  wbm_ack_i, wbm_dat_i,
        output cmd_ready,
        output rsp_valid, rsp_dat, rsp_err,
        output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o
    );

    modport slave (
        output cmd_valid, cmd_we, cmd_adr, cmd_dat, cmd_sel,
        output rsp_ready,
        output wbm_ack_i, wbm_dat_i,
        input  cmd_ready,
        input  rsp_valid, rsp_dat, rsp_err,
        input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o
    );

endinterface

// File: rtl/wb_cmd_timeout.sv
// Saturating bus-wait watchdog: expired_o is high on the TimeoutCycles-th enabled cycle.
module wb_cmd_timeout #(
    parameter int unsigned TimeoutCycles = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int unsigned CntW = $clog2(TimeoutCycles + 1);
    localparam logic [CntW-1:0] CntMax  = CntW'(TimeoutCycles);
    localparam logic [CntW-1:0] CntLast = CntW'(TimeoutCycles - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != CntMax)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The edge that would complete the TimeoutCycles-th wait cycle is the expiry edge.
    assign expired_o = (cnt_q >= CntLast);

endmodule

// File: rtl/wb_cmd_master.sv
// Valid/ready command stream to single Wishbone classic cycles.
// Define WB_CMD_MASTER_TIMEOUT_EN to enable the no-ack watchdog.
module wb_cmd_master
    import wb_cmd_master_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input logic                 wb_clk_i,
    input logic                 wb_rst_i,
    wb_cmd_master_if.master     bus
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES out of range 1..65535");
    end

    wbm_state_t      state_q, state_d;
    logic            cmd_ready_q, cmd_ready_d;
    logic            cyc_q, cyc_d;
    logic            stb_q, stb_d;
    logic            we_q, we_d;
    logic [AdrW-1:0] adr_q, adr_d;
    logic [DatW-1:0] dat_q, dat_d;
    logic [SelW-1:0] sel_q, sel_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [DatW-1:0] rsp_dat_q, rsp_dat_d;
    logic            rsp_err_q, rsp_err_d;

    logic cmd_hs;
    logic expired;

    assign cmd_hs = bus.cmd_valid && cmd_ready_q;

`ifdef WB_CMD_MASTER_TIMEOUT_EN
    wb_cmd_timeout #(
        .TimeoutCycles (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk_i     (wb_clk_i),
        .rst_i     (wb_rst_i),
        .clr_i     (cmd_hs),
        .en_i      (state_q == StBus),
        .expired_o (expired)
    );
`else
    assign expired = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        cyc_d       = cyc_q;
        stb_d       = stb_q;
        we_d        = we_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        sel_d       = sel_q;
        rsp_valid_d = rsp_valid_q;
        rsp_dat_d   = rsp_dat_q;
        rsp_err_d   = rsp_err_q;

        unique case (state_q)
            StIdle: begin
                if (cmd_hs) begin
                    we_d    = bus.cmd_we;
                    adr_d   = bus.cmd_adr;
                    dat_d   = bus.cmd_dat;
                    sel_d   = bus.cmd_sel;
                    cyc_d   = 1'b1;
                    stb_d   = 1'b1;
                    state_d = StBus;
                end
            end
            StBus: begin
                // Ack is checked first so a last-cycle ack still returns data.
                if (bus.wbm_ack_i) begin
                    rsp_dat_d   = we_q ? '0 : bus.wbm_dat_i;
                    rsp_err_d   = 1'b0;
                    cyc_d       = 1'b0;
                    stb_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = StResp;
                end else if (expired) begin
                    rsp_dat_d   = '0;
                    rsp_err_d   = 1'b1;
                    cyc_d       = 1'b0;
                    stb_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = StResp;
                end
            end
            StResp: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        cmd_ready_d = (state_d == StIdle);
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q     <= StIdle;
            cmd_ready_q <= 1'b0;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            we_q        <= 1'b0;
            adr_q       <= '0;
            dat_q       <= '0;
            sel_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_dat_q   <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            cyc_q       <= cyc_d;
            stb_q       <= stb_d;
            we_q        <= we_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            sel_q       <= sel_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_dat_q   <= rsp_dat_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.wbm_cyc_o = cyc_q;
    assign bus.wbm_stb_o = stb_q;
    assign bus.wbm_we_o  = we_q;
    assign bus.wbm_adr_o = adr_q;
    assign bus.wbm_dat_o = dat_q;
    assign bus.wbm_sel_o = sel_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_dat   = rsp_dat_q;
    assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_wb_cmd_master.sv
// Directed scoreboard bench for wb_cmd_master with a wait-state programmable responder.
module tb_wb_cmd_master;

    typedef struct packed {
        logic [31:0] dat;
        logic        err;
    } rsp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wb_cmd_master_if bus ();

    wb_cmd_master #(
        .TIMEOUT_CYCLES (8)
    ) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .bus      (bus)
    );

    int tests = 0;
    int fails = 0;
    rsp_t sb[$];

    // Responder model
    bit          ack_en    = 1'b0;
    bit          force_ack = 1'b0;
    int          ack_wait  = 0;
    int          wait_cnt  = 0;
    logic [31:0] rd_data   = '0;

    assign bus.wbm_ack_i = force_ack || (bus.wbm_stb_o && ack_en && (wait_cnt == ack_wait));
    assign bus.wbm_dat_i = rd_data;

    always @(posedge clk) begin
        if (!bus.wbm_stb_o || bus.wbm_ack_i) wait_cnt <= 0;
        else                                 wait_cnt <= wait_cnt + 1;
    end

    logic        exp_we;
    logic [31:0] exp_adr, exp_dat;
    logic [3:0]  exp_sel;
    int          stb_cnt = 0;

    task automatic chk32(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Bus and response monitor, sampled mid-cycle.
    always @(negedge clk) begin
        rsp_t r;
        if (bus.wbm_stb_o) begin
            stb_cnt++;
            chk32({28'd0, bus.wbm_cyc_o, bus.wbm_we_o, 2'd0}, {28'd0, 1'b1, exp_we, 2'd0},
                  "bus_cyc_we");
            chk32(bus.wbm_adr_o, exp_adr, "bus_adr");
            chk32(bus.wbm_dat_o, exp_dat, "bus_dat");
            chk32({28'd0, bus.wbm_sel_o}, {28'd0, exp_sel}, "bus_sel");
        end
        if (bus.rsp_valid && bus.rsp_ready) begin
            chk32(32'(sb.size() != 0), 32'd1, "rsp_expected");
            if (sb.size() != 0) begin
                r = sb.pop_front();
                chk32(bus.rsp_dat, r.dat, "rsp_dat");
                chk32({31'd0, bus.rsp_err}, {31'd0, r.err}, "rsp_err");
            end
        end
    end

    task automatic chk_all_zero(input string tag);
        chk32({26'd0, bus.cmd_ready, bus.wbm_cyc_o, bus.wbm_stb_o, bus.wbm_we_o,
               bus.rsp_valid, bus.rsp_err}, 32'd0, {tag, "_ctl"});
        chk32(bus.wbm_adr_o, 32'd0, {tag, "_adr"});
        chk32(bus.wbm_dat_o, 32'd0, {tag, "_dat"});
        chk32({28'd0, bus.wbm_sel_o}, 32'd0, {tag, "_sel"});
        chk32(bus.rsp_dat, 32'd0, {tag, "_rsp_dat"});
    endtask

    // Entered just after a rising edge; returns just after the command handshake edge.
    task automatic send_cmd(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                            input logic [3:0] sel);
        int n;
        exp_we = we; exp_adr = adr; exp_dat = dat; exp_sel = sel;
        bus.cmd_we = we; bus.cmd_adr = adr; bus.cmd_dat = dat; bus.cmd_sel = sel;
        bus.cmd_valid = 1'b1;
        stb_cnt = 0;
        n = 0;
        @(negedge clk);
        while (!bus.cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk32(32'(n < 20), 32'd1, "cmd_accept");
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
    endtask

    // n = index of the first cycle after the handshake edge in which rsp_valid is high.
    task automatic wait_rsp(output int n);
        n = 1;
        @(negedge clk);
        while (!bus.rsp_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk32(32'(bus.rsp_valid), 32'd1, "rsp_arrives");
    endtask

    task automatic run_cmd(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, input logic [31:0] rdat, input int wait_n,
                           input bit acks, input logic [31:0] e_dat, input logic e_err,
                           input int e_stb, input string tag);
        int n;
        rsp_t r;
        ack_en = acks; ack_wait = wait_n; rd_data = rdat;
        r.dat = e_dat; r.err = e_err;
        sb.push_back(r);
        send_cmd(we, adr, dat, sel);
        wait_rsp(n);
        chk32(n, e_stb + 1, {tag, "_latency"});
        chk32(stb_cnt, e_stb, {tag, "_stb_cycles"});
        chk32({31'd0, bus.wbm_cyc_o}, 32'd0, {tag, "_cyc_dropped"});
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: observed no finish expected finish");
        $fatal(1, "bench hung");
    end

    initial begin
        int   n;
        rsp_t r;
        bus.cmd_valid = 1'b0; bus.cmd_we = 1'b0; bus.cmd_adr = '0; bus.cmd_dat = '0;
        bus.cmd_sel = '0; bus.rsp_ready = 1'b1;

        @(negedge clk);
        chk_all_zero("reset");
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk32({31'd0, bus.cmd_ready}, 32'd1, "ready_after_reset");
        @(posedge clk);
        #1;

        run_cmd(1'b1, 32'h3000_0004, 32'hDEAD_BEEF, 4'hF, 32'hAAAA_5555, 0, 1'b1,
                32'h0, 1'b0, 1, "write0ws");
        run_cmd(1'b0, 32'h3000_0010, 32'h0, 4'h3, 32'h1234_5678, 3, 1'b1,
                32'h1234_5678, 1'b0, 4, "read3ws");
`ifdef WB_CMD_MASTER_TIMEOUT_EN
        run_cmd(1'b0, 32'h3000_0020, 32'h0, 4'hF, 32'h5555_AAAA, 0, 1'b0,
                32'h0, 1'b1, 8, "timeout");
`else
        run_cmd(1'b0, 32'h3000_0020, 32'h0, 4'hF, 32'h5555_AAAA, 20, 1'b1,
                32'h5555_AAAA, 1'b0, 21, "longwait");
`endif
        run_cmd(1'b0, 32'h3000_0024, 32'h0, 4'hC, 32'hCAFE_F00D, 7, 1'b1,
                32'hCAFE_F00D, 1'b0, 8, "ack_last");

        // Response back-pressure with a queued command and stray acks in RESP.
        bus.rsp_ready = 1'b0;
        ack_en = 1'b1; ack_wait = 0; rd_data = 32'h0BAD_F00D;
        r.dat = 32'h0BAD_F00D; r.err = 1'b0;
        sb.push_back(r);
        send_cmd(1'b0, 32'h3000_0030, 32'h0, 4'hF);
        wait_rsp(n);
        chk32(n, 2, "hold_latency");
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b1; bus.cmd_we = 1'b1; bus.cmd_adr = 32'h3000_0034;
        force_ack = 1'b1; rd_data = 32'hFFFF_0000;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk32({29'd0, bus.rsp_valid, bus.cmd_ready, bus.wbm_cyc_o}, 32'b100, "hold_ctl");
            chk32(bus.rsp_dat, 32'h0BAD_F00D, "hold_dat");
        end
        @(posedge clk);
        #1 force_ack = 1'b0; bus.rsp_ready = 1'b1;
        r.dat = 32'h0; r.err = 1'b0;
        sb.push_back(r);
        send_cmd(1'b1, 32'h3000_0034, 32'h0000_00A5, 4'h1);
        wait_rsp(n);
        chk32(n, 2, "queued_latency");
        chk32(stb_cnt, 1, "queued_stb_cycles");
        @(posedge clk);
        #1;

        // Stray ack while idle must not create a response.
        force_ack = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk32({30'd0, bus.rsp_valid, bus.cmd_ready}, 32'b01, "idle_ack_ignored");
        end
        @(posedge clk);
        #1 force_ack = 1'b0;

        // Asynchronous reset in the middle of a bus cycle.
        ack_en = 1'b0;
        send_cmd(1'b0, 32'h3000_0040, 32'h0, 4'hF);
        @(negedge clk);
        chk32({31'd0, bus.wbm_stb_o}, 32'd1, "pre_reset_stb");
        #2 rst = 1'b1;
        #1 chk_all_zero("async_reset");
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk32({30'd0, bus.cmd_ready, bus.rsp_valid}, 32'b10, "post_reset_ready");
        repeat (3) begin
            @(negedge clk);
            chk32({31'd0, bus.rsp_valid}, 32'd0, "no_spurious_rsp");
        end
        @(posedge clk);
        #1;

        run_cmd(1'b0, 32'h3000_0044, 32'h0, 4'hF, 32'h8765_4321, 1, 1'b1,
                32'h8765_4321, 1'b0, 2, "read_after_reset");

        chk32(sb.size(), 0, "scoreboard_drained");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
